// File: rtl/sprite_print_engine.sv
// sprite_print_engine: latches sprite descriptors once per frame and resolves the top sprite per pixel
// through a fixed 3-register pipeline (input sample, hit/memory return, colour output).
module sprite_print_engine #(
   parameter int N_SPRITES = 4,
   parameter int SIZE = 20,
   parameter int COLOR_W = 3,
   parameter int ADDR_W = 14,
   parameter int OFF_W = 9,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter logic [3*COLOR_W-1:0] BG_COLOR = '0,
   localparam int NR_W = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
   localparam int D_W = 21 + OFF_W,
   localparam int C_W = $clog2(N_SPRITES + 1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [D_W-1:0]     data_reg,
   output logic [NR_W-1:0]    n_register,
   input  logic [3*COLOR_W:0] data_memory,
   output logic [ADDR_W-1:0]  address_memory,
   input  logic               active_area,
   input  logic [10:0]        pixel_x,
   input  logic [9:0]         pixel_y,
   output logic [COLOR_W-1:0] R,
   output logic [COLOR_W-1:0] G,
   output logic [COLOR_W-1:0] B,
   output logic               printing_screen,
   output logic               frame_done
);
   typedef enum logic [1:0] {WAIT_VBLANK, LOAD, WAIT_FRAME, DRAW} state_t;
   state_t state_q, state_d;
   logic [C_W-1:0] cnt_q, cnt_d;
   logic [D_W-1:0] desc_q [N_SPRITES];
   logic [10:0] px_q;
   logic [9:0] py_q;
   logic act_q, act2_q, hit_q, hit;
   logic [3*COLOR_W-1:0] rgb_q, rgb_d;
   logic [N_SPRITES-1:0] in_spr;
   logic [ADDR_W-1:0] slot_addr [N_SPRITES];
   logic [11:0] px12, py12;
   logic vblank, frame_start;

   assign vblank = (pixel_y == 10'(V_ACTIVE)) && (pixel_x == '0);
   assign frame_start = (pixel_y == '0) && (pixel_x == '0);
   assign px12 = {1'b0, px_q};
   assign py12 = {2'b0, py_q};
   assign printing_screen = (state_q == DRAW);
   assign {R, G, B} = rgb_q;

   always_comb begin
      state_d = state_q;
      cnt_d = '0;
      frame_done = 1'b0;
      n_register = '0;
      case (state_q)
         WAIT_VBLANK, DRAW: state_d = vblank ? LOAD : state_q;
         LOAD: begin
            n_register = cnt_q[NR_W-1:0];
            cnt_d = cnt_q + C_W'(1);
            if (cnt_q == C_W'(N_SPRITES)) begin
               frame_done = 1'b1;
               cnt_d = '0;
               state_d = WAIT_FRAME;
            end
         end
         WAIT_FRAME: state_d = frame_start ? DRAW : state_q;
         default: state_d = WAIT_VBLANK;
      endcase
   end

   // Sprites are clipped at the visible right edge; 12-bit compares never wrap.
   for (genvar i = 0; i < N_SPRITES; i++) begin : g_hit
      logic [11:0] sx, sy;
      assign sx = {2'b0, desc_q[i][D_W-2 -: 10]};
      assign sy = {2'b0, desc_q[i][OFF_W+9 -: 10]};
      assign in_spr[i] = desc_q[i][D_W-1] && (px_q < 11'(H_ACTIVE))
                         && (px12 >= sx) && (px12 < sx + 12'(SIZE))
                         && (py12 >= sy) && (py12 < sy + 12'(SIZE));
      assign slot_addr[i] = ADDR_W'(32'(desc_q[i][OFF_W-1:0]) * 32'(SIZE * SIZE)
                            + 32'(py12 - sy) * 32'(SIZE) + 32'(px12 - sx));
   end

   always_comb begin
      hit = |in_spr;
      address_memory = '0;
      for (int i = N_SPRITES - 1; i >= 0; i--)
         if (in_spr[i]) address_memory = slot_addr[i];
   end

   assign rgb_d = !act2_q ? '0
                : (!hit_q || data_memory[3*COLOR_W]) ? BG_COLOR
                : data_memory[3*COLOR_W-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_VBLANK;
         cnt_q <= '0;
         px_q <= '0;
         py_q <= '0;
         act_q <= 1'b0;
         act2_q <= 1'b0;
         hit_q <= 1'b0;
         rgb_q <= '0;
         for (int i = 0; i < N_SPRITES; i++) desc_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         px_q <= pixel_x;
         py_q <= pixel_y;
         act_q <= active_area;
         act2_q <= act_q;
         hit_q <= hit;
         rgb_q <= rgb_d;
         for (int i = 0; i < N_SPRITES; i++)
            if (state_q == LOAD && cnt_q == C_W'(i + 1)) desc_q[i] <= data_reg;
      end
   end
endmodule

// File: tb/tb_sprite_print_engine.sv
// tb_sprite_print_engine: directed and randomized pixel streams against a behavioural sprite model.
module tb_sprite_print_engine;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [29:0] data_reg = '0;
   logic [1:0] n_register;
   logic [9:0] data_memory = '0;
   logic [13:0] address_memory;
   logic active_area = 1'b0;
   logic [10:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [2:0] R, G, B;
   logic printing_screen, frame_done;

   localparam logic [8:0] BG = 9'd0;

   int checks = 0;
   int errors = 0;
   logic [29:0] regs [4];
   logic [29:0] m_desc [4];
   logic [9:0] mem [16384];
   logic [13:0] ae;
   bit av;
   logic [8:0] rh [3];
   bit rv [3];

   sprite_print_engine dut (
      .clk(clk), .reset_n(reset_n), .data_reg(data_reg), .n_register(n_register),
      .data_memory(data_memory), .address_memory(address_memory), .active_area(active_area),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .R(R), .G(G), .B(B),
      .printing_screen(printing_screen), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Register bank and sprite memory each answer one clock after being addressed.
   always @(posedge clk) data_reg <= regs[n_register];
   always @(posedge clk) data_memory <= mem[address_memory];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input int x, input int y, input bit act, output bit hit,
                                 output logic [13:0] a, output logic [8:0] rgb);
      int w, sx, sy, off;
      w = -1;
      a = '0;
      for (int i = 0; i < 4 && w < 0; i++) begin
         sx = int'(m_desc[i][28:19]);
         sy = int'(m_desc[i][18:9]);
         if (m_desc[i][29] && x >= sx && x < sx + 20 && y >= sy && y < sy + 20) w = i;
      end
      hit = (w >= 0);
      if (hit) begin
         sx = int'(m_desc[w][28:19]);
         sy = int'(m_desc[w][18:9]);
         off = int'(m_desc[w][8:0]);
         a = 14'(off * 400 + (y - sy) * 20 + (x - sx));
      end
      rgb = !act ? 9'd0 : (!hit || mem[a][9]) ? BG : mem[a][8:0];
   endfunction

   task automatic step(input int x, input int y, input bit act, input bit chk_a = 1'b1);
      bit h;
      logic [13:0] a;
      logic [8:0] c;
      @(negedge clk);
      if (av) chk("addr", 32'(address_memory), 32'(ae));
      if (rv[2]) chk("rgb", 32'({R, G, B}), 32'(rh[2]));
      rh[2] = rh[1]; rv[2] = rv[1];
      rh[1] = rh[0]; rv[1] = rv[0];
      model(x, y, act, h, a, c);
      rh[0] = c; rv[0] = 1'b1;
      ae = a; av = h && chk_a;
      pixel_x = 11'(x);
      pixel_y = 10'(y);
      active_area = act;
   endtask

   task automatic do_load();
      step(0, 480, 1'b0, 1'b0);
      for (int k = 0; k <= 4; k++) begin
         step(k + 1, 480, 1'b0, 1'b0);
         if (k < 4) chk("n_register", 32'(n_register), 32'(k));
         chk("frame_done", 32'(frame_done), 32'(k == 4));
         chk("printing_in_load", 32'(printing_screen), 32'd0);
      end
      for (int i = 0; i < 4; i++) m_desc[i] = regs[i];
      step(6, 480, 1'b0, 1'b0);
      chk("frame_done_low", 32'(frame_done), 32'd0);
   endtask

   task automatic start_frame();
      step(0, 0, 1'b1);
      chk("printing_before_draw", 32'(printing_screen), 32'd0);
      step(1, 0, 1'b1);
      chk("printing_in_draw", 32'(printing_screen), 32'd1);
   endtask

   function automatic int clamp(input int v, input int hi);
      return (v < 0) ? 0 : (v > hi) ? hi : v;
   endfunction

   task automatic random_pixels(input int n);
      int j;
      for (int s = 0; s < n; s++) begin
         j = $urandom_range(0, 3);
         step(clamp(int'(m_desc[j][28:19]) + int'($urandom_range(0, 29)) - 5, 639),
              clamp(int'(m_desc[j][18:9]) + int'($urandom_range(0, 29)) - 5, 479),
              $urandom_range(0, 7) != 0);
      end
   endtask

   task automatic set_directed_regs();
      regs[0] = {1'b1, 10'd100, 10'd50, 9'd2};
      regs[1] = {1'b1, 10'd195, 10'd195, 9'd5};
      regs[2] = {1'b1, 10'd630, 10'd300, 9'd7};
      regs[3] = {1'b1, 10'd190, 10'd190, 9'd1};
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 10'($urandom);
      mem[865] = 10'b0_111_000_000;
      mem[821] = 10'b1_111_111_111;
      mem[2105] = 10'b0_001_010_011;
      mem[610] = 10'b0_110_101_100;
      mem[2809] = 10'b0_010_010_010;
      for (int i = 0; i < 4; i++) begin
         regs[i] = '0;
         m_desc[i] = '0;
      end
      for (int i = 0; i < 3; i++) rv[i] = 1'b0;
      av = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_rgb", 32'({R, G, B}), 32'd0);
      chk("rst_n_register", 32'(n_register), 32'd0);
      chk("rst_address", 32'(address_memory), 32'd0);
      chk("rst_printing", 32'(printing_screen), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      reset_n = 1'b1;

      set_directed_regs();
      step(0, 0, 1'b1);
      step(105, 53, 1'b1);
      chk("no_draw_before_load", 32'(printing_screen), 32'd0);
      step(200, 200, 1'b1);
      step(639, 300, 1'b1);

      do_load();
      start_frame();
      step(105, 53, 1'b1);
      step(120, 53, 1'b1);
      chk("addr_865", 32'(address_memory), 32'd865);
      step(101, 51, 1'b1);
      step(200, 200, 1'b1);
      chk("rgb_105_53", 32'({R, G, B}), 32'o700);
      step(105, 53, 1'b0);
      step(639, 300, 1'b1);
      step(5, 300, 1'b1);
      step(9, 300, 1'b1);
      step(119, 69, 1'b1);
      step(100, 70, 1'b1);
      random_pixels(150);

      regs[1][29] = 1'b0;
      do_load();
      start_frame();
      step(200, 200, 1'b1);
      step(205, 205, 1'b1);
      step(212, 212, 1'b1);
      random_pixels(60);

      for (int i = 0; i < 4; i++)
         regs[i] = {1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 639)),
                    10'($urandom_range(0, 479)), 9'($urandom_range(0, 40))};
      do_load();
      start_frame();
      random_pixels(300);

      step(100, 100, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_rgb", 32'({R, G, B}), 32'd0);
      chk("async_rst_printing", 32'(printing_screen), 32'd0);
      for (int i = 0; i < 3; i++) rv[i] = 1'b0;
      av = 1'b0;
      for (int i = 0; i < 4; i++) m_desc[i] = '0;
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 0, 1'b1);
      step(100, 100, 1'b1);
      chk("no_draw_after_reset", 32'(printing_screen), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(int'(regs[i][28:19]) + 3, clamp(int'(regs[i][18:9]) + 3, 479), 1'b1);
      end

      set_directed_regs();
      do_load();
      start_frame();
      step(105, 53, 1'b1);
      step(200, 200, 1'b1);
      step(639, 300, 1'b1);
      random_pixels(40);
      repeat (3) step(0, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
